hazard_scoreboard: RTL

//  Parametrised operand-forwarding and interlock unit for the ID stage of the MIPS pipeline.
//  A per-register scoreboard of countdown timers tracks results from multi-cycle producers:

---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage interlock and operand forwarding: per-register countdown scoreboard for LOAD/MUL results.
// Optional performance counters are compiled in with `define HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_flush,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_we,
  input  logic [4:0]        id_wa,
  input  logic [1:0]        id_lat_cls,
  input  logic [DATA_W-1:0] rs_data_in,
  input  logic [DATA_W-1:0] rt_data_in,
  input  logic              ex_we,
  input  logic [4:0]        ex_wa,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_we,
  input  logic [4:0]        mem_wa,
  input  logic [DATA_W-1:0] mem_data,
`ifdef HAZARD_PERF_EN
  input  logic              perf_clr,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_waw_stalls,
`endif
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              stall
);

  localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] MUL_C  = CNT_W'(MUL_LAT);

  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]       new_lat;
  logic                   hz_rs, hz_rt, waw, issue, live;

  always_comb begin
    case (id_lat_cls)
      2'd1:    new_lat = LOAD_C;
      2'd2:    new_lat = MUL_C;
      default: new_lat = '0;
    endcase
  end

  assign live  = id_valid & ~id_flush;
  assign hz_rs = id_rs_used & (id_rs_addr != 5'd0) & (cnt_q[id_rs_addr] != '0);
  assign hz_rt = id_rt_used & (id_rt_addr != 5'd0) & (cnt_q[id_rt_addr] != '0);
  // Refuse a write that would retire before an older pending write to the same register.
  assign waw   = id_we & (id_wa != 5'd0) & (cnt_q[id_wa] > new_lat);
  assign stall = live & (hz_rs | hz_rt | waw);
  assign issue = live & ~stall & id_we & (id_wa != 5'd0);

  always_comb begin
    cnt_d = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
      if (issue && id_wa == 5'(i)) cnt_d[i] = new_lat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  function automatic logic [DATA_W-1:0] fwd(input logic [4:0] a, input logic [DATA_W-1:0] rf);
    if (a == 5'd0)                fwd = '0;
    else if (ex_we && ex_wa == a)   fwd = ex_data;
    else if (mem_we && mem_wa == a) fwd = mem_data;
    else                          fwd = rf;
  endfunction

  assign rs_data = fwd(id_rs_addr, rs_data_in);
  assign rt_data = fwd(id_rt_addr, rt_data_in);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, waw_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      waw_cnt_q   <= '0;
    end else if (perf_clr) begin
      stall_cnt_q <= '0;
      waw_cnt_q   <= '0;
    end else begin
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (stall && waw && !hz_rs && !hz_rt && waw_cnt_q != 32'hFFFF_FFFF)
        waw_cnt_q <= waw_cnt_q + 32'd1;
    end
  end
  assign perf_stall_cycles = stall_cnt_q;
  assign perf_waw_stalls   = waw_cnt_q;
`endif

endmodule
